// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX data memory: access-size codes, FSM states
// and the alignment rule used to flag faulting accesses.
package dlx_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Reserved size, odd halfword or non-word-aligned word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_RSVD) ||
           ((size == SIZE_HALF) && off[0]) ||
           ((size == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dlx_data_ram_if.sv
// Request/response bus between the load/store stage (master) and the data RAM (slave).
interface dlx_data_ram_if #(
  parameter int ADDR_W = 18
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              sign_i;
  logic [ADDR_W-1:0] adr_i;
  logic [31:0]       data_i;
  logic              clr_i;
  logic              ready_o;
  logic              busy_o;
  logic              rvalid_o;
  logic [31:0]       data_o;
  logic              err_o;
  logic [31:0]       mem_addr_in_use;
  logic [31:0]       mem_addr_in_use_value;

  modport master (
    output req_i, we_i, size_i, sign_i, adr_i, data_i, clr_i,
    input  ready_o, busy_o, rvalid_o, data_o, err_o,
           mem_addr_in_use, mem_addr_in_use_value
  );

  modport slave (
    input  req_i, we_i, size_i, sign_i, adr_i, data_i, clr_i,
    output ready_o, busy_o, rvalid_o, data_o, err_o,
           mem_addr_in_use, mem_addr_in_use_value
  );
endinterface

// File: rtl/dlx_mem_align.sv
// Big-endian lane steering: store byte-enables/data replication and
// load lane extraction with sign or zero extension.
module dlx_mem_align
  import dlx_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte offset 0 is the most significant lane.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    byte_sel = rword_i[7:0];
    case (off_i)
      2'd0: byte_sel = rword_i[31:24];
      2'd1: byte_sel = rword_i[23:16];
      2'd2: byte_sel = rword_i[15:8];
      2'd3: byte_sel = rword_i[7:0];
    endcase
    half_sel = off_i[1] ? rword_i[15:0] : rword_i[31:16];
  end

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b1000 >> off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        be_o    = off_i[1] ? 4'b0011 : 4'b1100;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_i & half_sel[15]}}, half_sel};
      end
      SIZE_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dlx_data_ram.sv
// DLX data memory: single-port word array with byte/half/word access,
// registered load response, fault reporting and a hardware clear engine.
module dlx_data_ram
  import dlx_mem_pkg::*;
#(
  parameter int          ADDR_W         = 18,
  parameter int          DEPTH          = 65536,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] INIT_VALUE     = 32'h0
) (
  input  logic           clk_i,
  input  logic           reset,
  dlx_data_ram_if.slave  bus
);

  localparam int     IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  logic [31:0]       mem [DEPTH];

  state_e            state_q;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic              ready_q, busy_q, rvalid_q, err_q;
  logic [31:0]       data_q, dbg_idx_q, dbg_val_q;

  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range, fault, accept;
  logic [31:0]       rd_word, load_data, wdata_lane, wmask, merged;
  logic [3:0]        be;

  assign word_idx = bus.adr_i[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign in_range = (32'(word_idx) < 32'(DEPTH));
  assign fault    = is_misaligned(bus.size_i, bus.adr_i[1:0]) || !in_range;
  assign accept   = bus.req_i & ready_q;
  assign rd_word  = in_range ? mem[mem_idx] : '0;

  dlx_mem_align u_align (
    .size_i  (bus.size_i),
    .sign_i  (bus.sign_i),
    .off_i   (bus.adr_i[1:0]),
    .wdata_i (bus.data_i),
    .rword_i (rd_word),
    .be_o    (be),
    .wdata_o (wdata_lane),
    .rdata_o (load_data)
  );

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{be[i]}};
  end
  assign merged = (rd_word & ~wmask) | (wdata_lane & wmask);

  // FSM with ready/busy kept as flops so they change only on clock edges.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      ready_q   <= (RESET_STATE == ST_IDLE);
      busy_q    <= (RESET_STATE == ST_CLEAR);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.clr_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      dbg_idx_q <= '0;
      dbg_val_q <= '0;
    end else begin
      rvalid_q <= accept & ~bus.we_i;
      err_q    <= accept & fault;
      if (accept && !bus.we_i) data_q <= fault ? 32'h0 : load_data;
      if (accept) begin
        dbg_idx_q <= 32'(word_idx);
        dbg_val_q <= rd_word;
      end
    end
  end

  // NOTE: the array has no reset; the clear engine initialises it instead.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_cnt_q] <= INIT_VALUE;
    end else if (accept && bus.we_i && !fault) begin
      mem[mem_idx] <= merged;
    end
  end

  assign bus.ready_o               = ready_q;
  assign bus.busy_o                = busy_q;
  assign bus.rvalid_o              = rvalid_q;
  assign bus.err_o                 = err_q;
  assign bus.data_o                = data_q;
  assign bus.mem_addr_in_use       = dbg_idx_q;
  assign bus.mem_addr_in_use_value = dbg_val_q;

endmodule

// File: tb/tb_dlx_data_ram.sv
// Self-checking bench for dlx_data_ram: directed vector table, clear/reset
// sequences and random accesses against a byte-array reference model.
module tb_dlx_data_ram;
  import dlx_mem_pkg::*;

  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] INIT   = 32'h0;

  logic clk_i = 1'b0;
  logic reset = 1'b0;
  always #5 clk_i = ~clk_i;

  dlx_data_ram_if #(.ADDR_W(ADDR_W)) bus();

  dlx_data_ram #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
  ) dut (
    .clk_i (clk_i),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  model_b [4*DEPTH];
  logic [31:0] model_last;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [7:0]  adr;
    logic [31:0] wd;
    logic        exp_rv;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    logic [31:0] iv;
    iv = INIT;
    for (int i = 0; i < 4*DEPTH; i++) begin
      logic [31:0] t;
      t = iv >> (8 * (3 - (i % 4)));
      model_b[i] = t[7:0];
    end
  endtask

  // Reference: memory is a flat big-endian byte array.
  task automatic model_access(input logic we, input logic [1:0] size, input logic sign,
                              input logic [7:0] adr, input logic [31:0] wd,
                              output logic rv, output logic err, output logic [31:0] rd,
                              output logic [31:0] dbg_idx, output logic [31:0] dbg_val);
    int a, w, nb;
    logic [31:0] val, m;
    a  = int'(adr);
    w  = a / 4;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (a % nb != 0) || (w >= DEPTH);
    dbg_idx = 32'(w);
    dbg_val = 32'h0;
    if (w < DEPTH) dbg_val = {model_b[4*w], model_b[4*w+1], model_b[4*w+2], model_b[4*w+3]};
    rv = !we;
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) begin
          logic [31:0] t;
          t = wd >> (8 * (nb - 1 - k));
          model_b[a+k] = t[7:0];
        end
      end else begin
        val = 32'h0;
        for (int k = 0; k < nb; k++) val = (val << 8) | 32'(model_b[a+k]);
        m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        if (sign && nb < 4 && val[8*nb-1]) val = val | ~m;
        rd = val;
      end
    end
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic sign,
                        input logic [7:0] adr, input logic [31:0] wd, input logic clr,
                        output logic rv, output logic err, output logic [31:0] rd,
                        output logic [31:0] idx, output logic [31:0] val);
    bus.req_i  = 1'b1;
    bus.we_i   = we;
    bus.size_i = size;
    bus.sign_i = sign;
    bus.adr_i  = adr;
    bus.data_i = wd;
    bus.clr_i  = clr;
    @(posedge clk_i);
    #1;
    rv  = bus.rvalid_o;
    err = bus.err_o;
    rd  = bus.data_o;
    idx = bus.mem_addr_in_use;
    val = bus.mem_addr_in_use_value;
    bus.req_i = 1'b0;
    bus.clr_i = 1'b0;
  endtask

  // Model-checked access; compares every response field.
  task automatic mchk(input string tag, input logic we, input logic [1:0] size, input logic sign,
                      input logic [7:0] adr, input logic [31:0] wd);
    logic m_rv, m_err, d_rv, d_err;
    logic [31:0] m_rd, m_idx, m_val, d_rd, d_idx, d_val;
    model_access(we, size, sign, adr, wd, m_rv, m_err, m_rd, m_idx, m_val);
    if (m_rv) model_last = m_rd;
    access(we, size, sign, adr, wd, 1'b0, d_rv, d_err, d_rd, d_idx, d_val);
    check({tag, ".rvalid"}, 32'(d_rv), 32'(m_rv));
    check({tag, ".err"}, 32'(d_err), 32'(m_err));
    check({tag, ".data"}, d_rd, model_last);
    check({tag, ".dbg_idx"}, d_idx, m_idx);
    check({tag, ".dbg_val"}, d_val, m_val);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (bus.busy_o && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, 32'(bus.ready_o), 32'd0);
    check({tag, ".busy"}, 32'(bus.busy_o), 32'd1);
    check({tag, ".rvalid"}, 32'(bus.rvalid_o), 32'd0);
    check({tag, ".err"}, 32'(bus.err_o), 32'd0);
    check({tag, ".data"}, bus.data_o, 32'h0);
    check({tag, ".dbg_idx"}, bus.mem_addr_in_use, 32'h0);
    check({tag, ".dbg_val"}, bus.mem_addr_in_use_value, 32'h0);
  endtask

  initial begin
    int n;
    logic d_rv, d_err;
    logic [31:0] d_rd, d_idx, d_val, hold;
    logic m_rv, m_err;
    logic [31:0] m_rd, m_idx, m_val;

    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.sign_i = 1'b0;
    bus.adr_i = '0;   bus.data_i = '0; bus.clr_i = 1'b0;
    model_last = 32'h0;

    // Directed vectors: {we, size, sign, adr, wdata, exp rvalid, exp err, exp data}
    vecs.push_back(vec_t'{1'b0, SIZE_WORD, 1'b0, 8'h3C, 32'h0,         1'b1, 1'b0, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b1, SIZE_WORD, 1'b0, 8'h10, 32'h8000_00F0, 1'b0, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b0, SIZE_BYTE, 1'b1, 8'h10, 32'h0,         1'b1, 1'b0, 32'hFFFF_FF80});
    vecs.push_back(vec_t'{1'b0, SIZE_BYTE, 1'b0, 8'h10, 32'h0,         1'b1, 1'b0, 32'h0000_0080});
    vecs.push_back(vec_t'{1'b0, SIZE_HALF, 1'b1, 8'h12, 32'h0,         1'b1, 1'b0, 32'h0000_00F0});
    vecs.push_back(vec_t'{1'b1, SIZE_WORD, 1'b0, 8'h10, 32'h1122_3344, 1'b0, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b1, SIZE_BYTE, 1'b0, 8'h11, 32'h0000_00AB, 1'b0, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b0, SIZE_WORD, 1'b1, 8'h10, 32'h0,         1'b1, 1'b0, 32'h11AB_3344});
    vecs.push_back(vec_t'{1'b0, SIZE_HALF, 1'b0, 8'h03, 32'h0,         1'b1, 1'b1, 32'h0});
    vecs.push_back(vec_t'{1'b1, SIZE_WORD, 1'b0, 8'h20, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b1, SIZE_WORD, 1'b0, 8'h22, 32'h1234_5678, 1'b0, 1'b1, 32'h0});
    vecs.push_back(vec_t'{1'b0, SIZE_WORD, 1'b0, 8'h20, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D});
    vecs.push_back(vec_t'{1'b0, SIZE_WORD, 1'b0, 8'h40, 32'h0,         1'b1, 1'b1, 32'h0});
    vecs.push_back(vec_t'{1'b1, SIZE_BYTE, 1'b0, 8'h41, 32'h0000_0055, 1'b0, 1'b1, 32'h0});
    vecs.push_back(vec_t'{1'b0, SIZE_RSVD, 1'b0, 8'h00, 32'h0,         1'b1, 1'b1, 32'h0});
    vecs.push_back(vec_t'{1'b0, SIZE_BYTE, 1'b1, 8'h23, 32'h0,         1'b1, 1'b0, 32'h0000_000D});
    vecs.push_back(vec_t'{1'b0, SIZE_HALF, 1'b1, 8'h20, 32'h0,         1'b1, 1'b0, 32'hFFFF_CAFE});
    vecs.push_back(vec_t'{1'b1, SIZE_HALF, 1'b0, 8'h22, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b0, SIZE_WORD, 1'b0, 8'h20, 32'h0,         1'b1, 1'b0, 32'hCAFE_BEEF});
    vecs.push_back(vec_t'{1'b1, SIZE_WORD, 1'b0, 8'h04, 32'h0000_0005, 1'b0, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b0, SIZE_WORD, 1'b0, 8'h04, 32'h0,         1'b1, 1'b0, 32'h0000_0005});

    // Reset and power-on clear
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("por");
    @(negedge clk_i);
    reset = 1'b1;
    #1;
    check("por.busy_after_release", 32'(bus.busy_o), 32'd1);
    wait_clear(n);
    check("por.clear_cycles", 32'(n), 32'(DEPTH));
    check("por.ready", 32'(bus.ready_o), 32'd1);
    model_clear();

    // Directed table, applied back to back
    hold = 32'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      model_access(vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].adr, vecs[i].wd,
                   m_rv, m_err, m_rd, m_idx, m_val);
      access(vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].adr, vecs[i].wd, 1'b0,
             d_rv, d_err, d_rd, d_idx, d_val);
      if (vecs[i].exp_rv) hold = vecs[i].exp_data;
      check({tag, ".rvalid"}, 32'(d_rv), 32'(vecs[i].exp_rv));
      check({tag, ".err"}, 32'(d_err), 32'(vecs[i].exp_err));
      check({tag, ".data"}, d_rd, hold);
      check({tag, ".dbg_idx"}, d_idx, 32'(vecs[i].adr >> 2));
      check({tag, ".dbg_val"}, d_val, m_val);
      check({tag, ".ready"}, 32'(bus.ready_o), 32'd1);
    end
    model_last = hold;

    // Random accesses with occasional idle cycles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk_i);
        #1;
        check("idle.rvalid", 32'(bus.rvalid_o), 32'd0);
        check("idle.err", 32'(bus.err_o), 32'd0);
        check("idle.data", bus.data_o, model_last);
      end else begin
        logic [1:0] sz;
        logic [7:0] adr;
        sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        adr = 8'($urandom_range(0, DEPTH + 3) * 4);
        if ($urandom_range(0, 7) == 0) adr = adr | 8'($urandom_range(0, 3));
        else if (sz == 2'd0) adr = adr | 8'($urandom_range(0, 3));
        else if (sz == 2'd1) adr = adr | 8'($urandom_range(0, 1) * 2);
        mchk("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), adr, $urandom);
      end
    end

    // Clear request together with a load: old data returned, clear follows
    mchk("pre_clr_store", 1'b1, SIZE_WORD, 1'b0, 8'h10, 32'h5A5A_1234);
    model_access(1'b0, SIZE_WORD, 1'b0, 8'h10, 32'h0, m_rv, m_err, m_rd, m_idx, m_val);
    access(1'b0, SIZE_WORD, 1'b0, 8'h10, 32'h0, 1'b1, d_rv, d_err, d_rd, d_idx, d_val);
    check("clr_load.rvalid", 32'(d_rv), 32'd1);
    check("clr_load.data", d_rd, 32'h5A5A_1234);
    check("clr_load.busy", 32'(bus.busy_o), 32'd1);
    check("clr_load.ready", 32'(bus.ready_o), 32'd0);
    model_last = m_rd;
    wait_clear(n);
    check("clr.cycles", 32'(n), 32'(DEPTH));
    model_clear();
    for (int w = 0; w < DEPTH; w++) mchk("after_clr", 1'b0, SIZE_WORD, 1'b0, 8'(w * 4), 32'h0);

    // Reset in the middle of a clear restarts it from word 0
    for (int w = 0; w < DEPTH; w++) mchk("fill", 1'b1, SIZE_WORD, 1'b0, 8'(w * 4), 32'hA000_0000 | 32'(w + 1));
    bus.clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.clr_i = 1'b0;
    check("midclr.busy", 32'(bus.busy_o), 32'd1);
    repeat (7) @(posedge clk_i);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("midclr_rst");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset = 1'b1;
    #1;
    wait_clear(n);
    check("midclr.cycles", 32'(n), 32'(DEPTH));
    model_clear();
    model_last = 32'h0;
    for (int w = 0; w < DEPTH; w++) mchk("after_rst_clr", 1'b0, SIZE_WORD, 1'b0, 8'(w * 4), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
